ps2_frame_rx: RTL and testbench

PS/2 keyboard front end. Synchronises the raw ps2_clk/ps2_data pins, deserialises 11-bit device-to-host frames, checks start/parity/stop, and queues valid scan-code bytes in a small FIFO read with a nextdata_n handshake. It sits directly upstream of the keyboard idle/sleep detector: its ps_data_sync output drives that stage's ps_data input, and its FIFO feeds the scan-code decoder.

---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_byte_fifo.sv | 44 ++++
 rtl/ps2_frame_rx.sv | 99 +++++++++
 tb/tb_ps2_frame_rx.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants for the PS/2 frame receiver
package ps2_pkg;

  localparam int   FRAME_BITS         = 11;
  localparam logic START_BIT          = 1'b0;
  localparam logic STOP_BIT           = 1'b1;
  localparam logic LINE_IDLE          = 1'b1;
  localparam int   DEFAULT_TIMEOUT    = 50000;
  localparam int   DEFAULT_FIFO_DEPTH = 8;

  // Odd parity holds when data plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// rtl/ps2_byte_fifo.sv - byte FIFO holding received scan codes
module ps2_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  logic [7:0]     mem [DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           do_pop;
  logic           do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop  = pop && !empty;
  // A write into a full FIFO is allowed when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PTR_W-1:0]] <= wdata;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 pin synchroniser, frame deserialiser and checker
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int PTR_W      = 3,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       parity_err,
  output logic       ps_data_sync
);

  localparam int         TO_W     = $clog2(TIMEOUT + 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  logic [2:0]      clk_sync;
  logic [2:0]      dat_sync;
  logic [3:0]      cnt;
  logic [TO_W-1:0] tcnt;
  logic [7:0]      dbuf;
  logic            par;
  logic            fall;
  logic            bit_in;
  logic            frame_ok;
  logic            push;
  logic            full;
  logic            empty;

  assign fall         = !clk_sync[1] && clk_sync[2];
  assign bit_in       = dat_sync[2];
  assign ps_data_sync = dat_sync[2];
  assign frame_ok     = (bit_in == STOP_BIT) && odd_parity_ok(dbuf, par);
  assign push         = fall && (cnt == LAST_BIT) && frame_ok;
  assign ready        = !empty;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_sync   <= {3{LINE_IDLE}};
      dat_sync   <= {3{LINE_IDLE}};
      cnt        <= 4'd0;
      tcnt       <= '0;
      dbuf       <= 8'h00;
      par        <= 1'b0;
      overflow   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[1:0], ps2_clk};
      dat_sync   <= {dat_sync[1:0], ps2_data};
      parity_err <= 1'b0;
      // Full and no pop this cycle: the FIFO refuses the byte.
      if (push && full && nextdata_n) overflow <= 1'b1;
      if (fall) begin
        tcnt <= '0;
        if (cnt == 4'd0) begin
          if (bit_in == START_BIT) cnt <= 4'd1;
        end else if (cnt <= 4'd8) begin
          dbuf <= {bit_in, dbuf[7:1]};
          cnt  <= cnt + 4'd1;
        end else if (cnt == 4'd9) begin
          par <= bit_in;
          cnt <= cnt + 4'd1;
        end else begin
          cnt <= 4'd0;
          if (!frame_ok) parity_err <= 1'b1;
        end
      end else if (cnt != 4'd0) begin
        if (tcnt == TO_W'(TIMEOUT)) begin
          cnt  <= 4'd0;
          tcnt <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

  ps2_byte_fifo #(
    .DEPTH(FIFO_DEPTH),
    .PTR_W(PTR_W)
  ) u_fifo (
    .clk  (clk),
    .clrn (clrn),
    .push (push),
    .pop  (!nextdata_n),
    .wdata(dbuf),
    .rdata(data),
    .full (full),
    .empty(empty)
  );

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb/tb_ps2_frame_rx.sv - directed self-checking bench for ps2_frame_rx
module tb_ps2_frame_rx;

  localparam int TB_TIMEOUT = 200;

  logic       clk;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       parity_err;
  logic       ps_data_sync;

  int errors = 0;
  int checks = 0;
  int pe_cycles = 0;

  ps2_frame_rx #(
    .FIFO_DEPTH(8),
    .PTR_W(3),
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .nextdata_n  (nextdata_n),
    .data        (data),
    .ready       (ready),
    .overflow    (overflow),
    .parity_err  (parity_err),
    .ps_data_sync(ps_data_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (parity_err) pe_cycles++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Stop bit is driven inline so a pop or latency check can be aligned to its detection.
  task automatic send_frame(input logic [7:0] d, input logic bad_par,
                            input logic pop_on_stop, input logic chk_lat);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(f[i]);
    ps2_data = f[10];
    repeat (2) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    if (chk_lat) check("lat_ready_on_detect", ready, 1'b0);
    if (pop_on_stop) nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
    if (chk_lat) begin
      check("lat_ready_after", ready, 1'b1);
      check("lat_data_after", data, d);
    end
    @(negedge clk);
    ps2_clk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_ready"}, ready, 1'b1);
    check({tag, "_data"}, data, exp);
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  initial begin
    clrn = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    nextdata_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b0);
    check("rst_data", data, 8'h00);
    check("rst_overflow", overflow, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_ps_data_sync", ps_data_sync, 1'b1);
    clrn = 1'b1;
    repeat (2) @(negedge clk);

    // Good 0x1C with latency check, then single pop.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
    pop_check("t1_pop", 8'h1C);
    check("t1_empty", ready, 1'b0);

    // 0x1C with wrong parity.
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    check("t2_pe_cycles", pe_cycles, 1);
    check("t2_ready", ready, 1'b0);
    check("t2_overflow", overflow, 1'b0);

    // Nine frames without popping: the ninth overflows.
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
    check("t3_ovf_after8", overflow, 1'b0);
    send_frame(8'h09, 1'b0, 1'b0, 1'b0);
    check("t3_ovf_after9", overflow, 1'b1);
    for (int i = 1; i <= 8; i++) pop_check($sformatf("t3_pop%0d", i), 8'(i));
    check("t3_empty", ready, 1'b0);
    check("t3_ovf_sticky", overflow, 1'b1);

    // Partial frame abandoned by timeout, then a clean 0xF0.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (TB_TIMEOUT + 5) @(negedge clk);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    pop_check("t4_pop", 8'hF0);
    check("t4_empty", ready, 1'b0);
    check("t4_pe_cycles", pe_cycles, 1);

    // Reset in the middle of a frame.
    send_bit(1'b0);
    for (int i = 0; i < 6; i++) send_bit(i[0]);
    ps2_data = 1'b0;
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_rst_ready", ready, 1'b0);
    check("t5_rst_data", data, 8'h00);
    check("t5_rst_overflow", overflow, 1'b0);
    check("t5_rst_parity_err", parity_err, 1'b0);
    check("t5_rst_ps_data_sync", ps_data_sync, 1'b1);
    ps2_data = 1'b1;
    clrn = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    pop_check("t5_pop", 8'h29);
    check("t5_empty", ready, 1'b0);

    // Full FIFO, ninth write coincides with a pop.
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
    send_frame(8'h18, 1'b0, 1'b1, 1'b0);
    check("t6_overflow", overflow, 1'b0);
    for (int i = 1; i <= 8; i++) pop_check($sformatf("t6_pop%0d", i), 8'h10 + 8'(i));
    check("t6_empty", ready, 1'b0);
    check("t6_overflow_end", overflow, 1'b0);
    check("t6_pe_cycles", pe_cycles, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
